// File: rtl/vector_pkg.sv
// Shared types and defaults for the vector display sequencer.
// State encoding, point-word field offsets and step-shift defaults.
package vector_pkg;

  typedef enum logic [2:0] {
    JUMP0,
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    HOLD,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    FLD_Y,
    FLD_X,
    FLD_COLOR,
    FLD_LIT
  } field_e;

  localparam logic [3:0] SHIFT_LIT_DEF   = 4'd1;
  localparam logic [3:0] SHIFT_BLANK_DEF = 4'd2;

  // Bit offset of a field in {lit, colour, x, y}.
  function automatic int fld_off(
    input field_e f,
    input int     coord_w,
    input int     num_ch,
    input int     color_w
  );
    int off;
    case (f)
      FLD_Y:     off = 0;
      FLD_X:     off = coord_w;
      FLD_COLOR: off = 2 * coord_w;
      default:   off = 2 * coord_w + num_ch * color_w;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/vector_sequencer_point_unpack.sv
// Point-word splitter for the vector sequencer.
// Purely combinational: {lit, colour, x, y} into fields.
module point_unpack
  import vector_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int NUM_CH  = 3,
  parameter int COLOR_W = 4
) (
  input  logic [NUM_CH*COLOR_W+2*COORD_W:0] word,
  output logic                              lit,
  output logic [NUM_CH*COLOR_W-1:0]         colour,
  output logic [COORD_W-1:0]                x,
  output logic [COORD_W-1:0]                y
);

  localparam int CW    = NUM_CH * COLOR_W;
  localparam int Y_OFF = fld_off(FLD_Y, COORD_W, NUM_CH, COLOR_W);
  localparam int X_OFF = fld_off(FLD_X, COORD_W, NUM_CH, COLOR_W);
  localparam int C_OFF = fld_off(FLD_COLOR, COORD_W, NUM_CH, COLOR_W);
  localparam int L_OFF = fld_off(FLD_LIT, COORD_W, NUM_CH, COLOR_W);

  assign y      = word[Y_OFF +: COORD_W];
  assign x      = word[X_OFF +: COORD_W];
  assign colour = word[C_OFF +: CW];
  assign lit    = word[L_OFF];

endmodule

// File: rtl/vector_sequencer.sv
// Vector display sequencer: walks a point buffer, issues draw/jump.
// Define VECTOR_SEQ_PARK_EN to park the beam at centre after each frame.
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int         COORD_W     = 12,
  parameter int         ADDR_W      = 11,
  parameter int         NUM_CH      = 3,
  parameter int         COLOR_W     = 4,
  parameter logic [3:0] SHIFT_LIT   = SHIFT_LIT_DEF,
  parameter logic [3:0] SHIFT_BLANK = SHIFT_BLANK_DEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              frame_valid,
  input  logic [ADDR_W-1:0]                 num_points,
  output logic [ADDR_W-1:0]                 rd_addr,
  input  logic [NUM_CH*COLOR_W+2*COORD_W:0] rd_data,
  output logic                              frame_done,
  input  logic                              ready,
  output logic [COORD_W-1:0]                x,
  output logic [COORD_W-1:0]                y,
  output logic                              draw,
  output logic                              jump,
  output logic [3:0]                        shift,
  output logic [NUM_CH*COLOR_W-1:0]         beam
);

  localparam int CW = NUM_CH * COLOR_W;

  logic [1:0]         rst_sync;
  logic               rst_n;
  state_e             state;
  logic [1:0]         hold_cnt;
  logic               pu_lit;
  logic [CW-1:0]      pu_colour;
  logic [COORD_W-1:0] pu_x;
  logic [COORD_W-1:0] pu_y;
  logic               pt_lit;
  logic [CW-1:0]      pt_colour;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;
  logic [ADDR_W-1:0]  next_addr;

`ifdef VECTOR_SEQ_PARK_EN
  localparam logic [COORD_W-1:0] CENTRE = COORD_W'(1) << (COORD_W - 1);
  logic parked;
`endif

  assign next_addr = rd_addr + ADDR_W'(1);
  assign rst_n     = rst_sync[1];

  point_unpack #(
    .COORD_W(COORD_W),
    .NUM_CH (NUM_CH),
    .COLOR_W(COLOR_W)
  ) u_unpack (
    .word  (rd_data),
    .lit   (pu_lit),
    .colour(pu_colour),
    .x     (pu_x),
    .y     (pu_y)
  );

  // Assert reset at once, release it two clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  // Sequencer FSM with registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= JUMP0;
      hold_cnt   <= '0;
      rd_addr    <= '0;
      x          <= '0;
      y          <= '0;
      shift      <= '0;
      beam       <= '0;
      draw       <= 1'b0;
      jump       <= 1'b0;
      frame_done <= 1'b0;
      pt_lit     <= 1'b0;
      pt_colour  <= '0;
      pt_x       <= '0;
      pt_y       <= '0;
`ifdef VECTOR_SEQ_PARK_EN
      parked     <= 1'b0;
`endif
    end else begin
      draw       <= 1'b0;
      jump       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        JUMP0: begin
          if (ready) begin
            jump  <= 1'b1;
            x     <= '0;
            y     <= '0;
            beam  <= '0;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (frame_valid) begin
            rd_addr <= '0;
            state   <= (num_points == '0) ? DONE : FETCH;
          end
        end
        FETCH, LOAD, ISSUE: begin
          if (!frame_valid) begin
            beam       <= '0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (state == FETCH) begin
            state <= LOAD;
          end else if (state == LOAD) begin
            pt_lit    <= pu_lit;
            pt_colour <= pu_colour;
            pt_x      <= pu_x;
            pt_y      <= pu_y;
            state     <= ISSUE;
          end else if (ready) begin
            draw     <= 1'b1;
            x        <= pt_x;
            y        <= pt_y;
            beam     <= pt_lit ? pt_colour : '0;
            shift    <= pt_lit ? SHIFT_LIT : SHIFT_BLANK;
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == 2'd2) begin
            if (next_addr == num_points) begin
              state <= DONE;
            end else begin
              rd_addr <= next_addr;
              state   <= FETCH;
            end
          end else begin
            hold_cnt <= hold_cnt + 2'd1;
          end
        end
        DONE: begin
`ifdef VECTOR_SEQ_PARK_EN
          if (ready && !parked) begin
            jump   <= 1'b1;
            x      <= CENTRE;
            y      <= CENTRE;
            beam   <= '0;
            parked <= 1'b1;
          end else if (ready) begin
            beam       <= '0;
            frame_done <= 1'b1;
            parked     <= 1'b0;
            state      <= IDLE;
          end
`else
          if (ready) begin
            beam       <= '0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
`endif
        end
        default: state <= JUMP0;
      endcase
    end
  end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter COORD_W, default 12, X/Y coordinate width.
REQ-002 SHALL have parameter ADDR_W, default 11, point-buffer address width.
REQ-003 SHALL have parameter NUM_CH, default 3, beam colour channels.
REQ-004 SHALL have parameter COLOR_W, default 4, intensity bits per channel.
REQ-005 SHALL have parameters SHIFT_LIT (default 1) and SHIFT_BLANK (default 2), each 4-bit, the step shift for lit and blanked moves.
REQ-006 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-007 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-008 Port: frame_valid  in  1  buffer holds a complete frame.
REQ-009 Port: num_points  in  ADDR_W  point count of the current frame.
REQ-010 Port: rd_addr  out  ADDR_W  point-buffer read address.
REQ-011 Port: rd_data  in  PW  point word, valid one cycle after rd_addr; PW = 1+NUM_CH*COLOR_W+2*COORD_W, layout {lit, colour[NUM_CH-1:0], x, y}.
REQ-012 Port: frame_done  out  1  one-cycle pulse at end or abort of a frame.
REQ-013 Port: ready  in  1  line drawer idle.
REQ-014 Port: x, y  out  COORD_W each  target coordinates.
REQ-015 Port: draw, jump  out  1 each  one-cycle command pulses to the line drawer.
REQ-016 Port: shift  out  4  step shift for the current move.
REQ-017 Port: beam  out  NUM_CH*COLOR_W  per-channel intensity; 0 means blanked.

Function
REQ-018 FSM states SHALL be: JUMP0, IDLE, FETCH, LOAD, ISSUE, HOLD, DONE.
REQ-019 JUMP0 SHALL, on the first ready after reset, pulse jump with x=y=0 and beam=0, then go to IDLE.
REQ-020 IDLE SHALL go to FETCH when frame_valid=1, with rd_addr=0.
REQ-021 FETCH SHALL present rd_addr and go to LOAD on the next cycle; LOAD SHALL capture rd_data.
REQ-022 ISSUE SHALL wait for ready=1. It then pulses draw for exactly one cycle, with x/y/shift updated in that same cycle.
REQ-023 On that draw, if lit=1: beam=colour field and shift=SHIFT_LIT; otherwise beam=0 and shift=SHIFT_BLANK.
REQ-024 HOLD SHALL ignore ready for the 2 cycles after draw.
REQ-025 After HOLD, the next point SHALL be fetched with rd_addr+1, or the FSM SHALL go to DONE when rd_addr+1 == num_points.
REQ-026 DONE SHALL wait for ready=1, then set beam=0, pulse frame_done for one cycle, and return to IDLE.
REQ-027 num_points=0 SHALL go IDLE->DONE with no draw.
REQ-028 rd_addr SHALL count modulo 2^ADDR_W; num_points=2^ADDR_W-1 SHALL draw every address 0..2^ADDR_W-2.
REQ-029 If frame_valid falls in FETCH, LOAD or ISSUE, the current point SHALL be dropped, with beam=0 and a frame_done pulse, then IDLE. A point already drawn SHALL be completed through HOLD first.
REQ-030 draw and jump SHALL never be high in the same cycle.
REQ-031 x, y, shift and beam SHALL hold their values between commands.

Reset
REQ-032 Asserting reset_n=0 SHALL immediately force state=JUMP0 and set x, y, rd_addr, shift, beam, draw, jump and frame_done to 0, including mid-frame.
REQ-033 Release SHALL be synchronised internally with a 2-flop deassertion.

Configuration
REQ-034 Macro VECTOR_SEQ_PARK_EN SHALL control parking.
REQ-035 With VECTOR_SEQ_PARK_EN defined, DONE SHALL also issue a blanked jump to the centre (2^(COORD_W-1), 2^(COORD_W-1)) before frame_done, adding one ready wait.
REQ-036 Without VECTOR_SEQ_PARK_EN, the beam SHALL stay at the last point, and DONE SHALL behave as in REQ-026.

Structure
REQ-037 Package vector_pkg SHALL hold the state enum, a point-word field-offset function, and the SHIFT_LIT/SHIFT_BLANK defaults.
REQ-038 Sub-module point_unpack SHALL be combinational and split rd_data into lit, colour, x and y.

Verification
REQ-039 Release reset with ready=1 -> one jump pulse at (0,0), beam=0, no draw.
REQ-040 3-point frame, lit/blank/lit, colours 0xF00/any/0x0A5, ready tied 1 -> three draw pulses spaced ≥4 cycles; beam 0xF00, 0x000, 0x0A5; shift 1, 2, 1; then one frame_done.
REQ-041 num_points=0 with frame_valid=1 -> frame_done within 3 cycles, no draw.
REQ-042 Drop frame_valid during the 2nd point's LOAD -> no 2nd draw, beam=0, one frame_done, IDLE.
REQ-043 reset_n low while ready=0 in HOLD -> all outputs 0 in the same cycle; the jump in REQ-039 recurs after release.
REQ-044 VECTOR_SEQ_PARK_EN defined, COORD_W=12 -> final blanked jump to (2048, 2048) precedes frame_done.
